// File: rtl/core_pkg.sv
// Shared types and defaults for the core memory arbiter and its round-robin picker.
package core_pkg;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      READ_WAIT = 2'd2
   } arb_state_t;

   // Width of a core index; kept at one bit minimum so a lone core is still addressable.
   function automatic int core_idx_w(input int num_cores);
      return (num_cores > 1) ? $clog2(num_cores) : 1;
   endfunction

endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping around.
module rr_pick
   import core_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int IDX_W     = core_idx_w(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [IDX_W-1:0]     winner,
   output logic                 any_req
);

   int idx;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path can infer a latch.
      winner  = '0;
      any_req = |req;
      idx     = 0;
      // Scan from farthest to nearest; the last hit (closest to rr_ptr) wins.
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_CORES;
         if (req[idx]) begin
            winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter serialising core accesses onto one single-port synchronous RAM.
// Define ARB_LOCK_EN to let a core hold the bus across accesses via its lock input.
module core_mem_arbiter
   import core_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                        clock,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        wr,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES*DATA_W-1:0] wdata,
   input  logic [NUM_CORES-1:0]        lock,
   output logic [NUM_CORES-1:0]        grant,
   output logic [NUM_CORES-1:0]        rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_we,
   input  logic [DATA_W-1:0]           mem_rdata
);

   localparam int IDX_W = core_idx_w(NUM_CORES);

   arb_state_t           state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [NUM_CORES-1:0] grant_d, rvalid_d;
   logic [DATA_W-1:0]    rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0]    mem_addr_d;
   logic                 mem_we_d;

   logic [IDX_W-1:0]     rr_winner;
   logic                 rr_any;
   logic [IDX_W-1:0]     win;
   logic [IDX_W-1:0]     ptr_next;
   logic                 keep_ptr;

   rr_pick #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_rr_pick (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .winner  (rr_winner),
      .any_req (rr_any)
   );

`ifdef ARB_LOCK_EN
   logic lock_hold;

   // A locked owner that still requests keeps the bus; the rotation point is frozen meanwhile.
   assign lock_hold = lock[owner_q] & req[owner_q];
   assign win       = lock_hold ? owner_q : rr_winner;
   assign keep_ptr  = lock_hold;
`else
   logic unused_lock;

   assign unused_lock = ^lock;
   assign win         = rr_winner;
   assign keep_ptr    = 1'b0;
`endif

   assign ptr_next = (win == IDX_W'(NUM_CORES - 1)) ? '0 : win + 1'b1;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      grant_d     = '0;
      rvalid_d    = '0;
      rdata_d     = rdata;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_we_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rr_any) begin
               mem_addr_d    = addr[win*ADDR_W +: ADDR_W];
               mem_wdata_d   = wdata[win*DATA_W +: DATA_W];
               mem_we_d      = wr[win];
               grant_d[win]  = 1'b1;
               owner_d       = win;
               state_d       = ISSUE;
               if (!keep_ptr) begin
                  rr_ptr_d = ptr_next;
               end
            end
         end
         // mem_we still carries the direction of the command on the bus this cycle.
         ISSUE: begin
            state_d = mem_we ? IDLE : READ_WAIT;
         end
         READ_WAIT: begin
            rdata_d           = mem_rdata;
            rvalid_d[owner_q] = 1'b1;
            state_d           = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         grant     <= '0;
         rvalid    <= '0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values together.
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         grant     <= grant_d;
         rvalid    <= rvalid_d;
         rdata     <= rdata_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_we    <= mem_we_d;
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: directed stimulus queues expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_core_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic            clock = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, wr, lock, grant, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]   mem_addr;
   logic            mem_we;
   logic [N-1:0]    hold;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          core;
      bit          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int          at;
   } grant_exp_t;

   typedef struct {
      int          core;
      logic [DW-1:0] d;
   } read_exp_t;

   grant_exp_t gq[$];
   read_exp_t  rq[$];
   int         last_gcyc [N];

   core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .req       (req),
      .wr        (wr),
      .addr      (addr),
      .wdata     (wdata),
      .lock      (lock),
      .grant     (grant),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous RAM model: unwritten locations return fixed preload values.
   bit [DW-1:0] mem [256];
   bit          written [256];

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 16'h0020) return 16'h1234;
      if (a == 16'h0030) return 16'h0777;
      if (a >= 16'h0040 && a <= 16'h0043) return 16'hA000 + (a - 16'h0040);
      return '0;
   endfunction

   always @(posedge clock) begin
      if (mem_we) begin
         mem[mem_addr[7:0]]     <= mem_wdata;
         written[mem_addr[7:0]] <= 1'b1;
      end
      mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin : monitor
      grant_exp_t ge;
      read_exp_t  re;
      int         k;
      forever begin
         @(negedge clock);
         if (!rst_n) begin
            check("reset_grant", grant, 0);
            check("reset_rvalid", rvalid, 0);
            check("reset_rdata", rdata, 0);
            check("reset_mem_addr", mem_addr, 0);
            check("reset_mem_wdata", mem_wdata, 0);
            check("reset_mem_we", mem_we, 0);
         end else begin
            if (grant != '0) begin
               check("grant_onehot", $onehot(grant), 1);
               k = 0;
               for (int i = 0; i < N; i++) if (grant[i]) k = i;
               last_gcyc[k] = cyc;
               if (gq.size() == 0) begin
                  check("grant_unexpected", grant, 0);
               end else begin
                  ge = gq.pop_front();
                  check("grant_core", k, ge.core);
                  check("grant_mem_we", mem_we, ge.we);
                  check("grant_mem_addr", mem_addr, ge.a);
                  check("grant_mem_wdata", mem_wdata, ge.d);
                  if (ge.at >= 0) check("grant_cycle", cyc, ge.at);
               end
            end else begin
               check("mem_we_without_grant", mem_we, 0);
            end
            if (rvalid != '0) begin
               check("rvalid_onehot", $onehot(rvalid), 1);
               k = 0;
               for (int i = 0; i < N; i++) if (rvalid[i]) k = i;
               if (rq.size() == 0) begin
                  check("rvalid_unexpected", rvalid, 0);
               end else begin
                  re = rq.pop_front();
                  check("rvalid_core", k, re.core);
                  check("rdata", rdata, re.d);
                  check("read_latency", cyc - last_gcyc[k], 2);
               end
            end
         end
      end
   end

   // Cores drop req once their grant is seen unless the scenario holds it.
   task automatic tick();
      @(negedge clock);
      req = req & ~(grant & ~hold);
   endtask

   task automatic drive(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[c]               = 1'b1;
      wr[c]                = w;
      addr[c*AW +: AW]     = a;
      wdata[c*DW +: DW]    = d;
   endtask

   task automatic exp_grant(input int c, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int at);
      grant_exp_t e;
      e.core = c; e.we = w; e.a = a; e.d = d; e.at = at;
      gq.push_back(e);
   endtask

   task automatic exp_read(input int c, input logic [DW-1:0] d);
      read_exp_t e;
      e.core = c; e.d = d;
      rq.push_back(e);
   endtask

   task automatic wait_until(input int target);
      int n = 0;
      while (cyc < target && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((gq.size() != 0 || rq.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      if (gq.size() != 0 || rq.size() != 0) begin
         check("drain_timeout_pending", gq.size() + rq.size(), 0);
         gq.delete();
         rq.delete();
      end
      repeat (2) tick();
   endtask

   initial begin : stimulus
      int c;
      rst_n = 1'b0;
      req   = '0;
      wr    = '0;
      lock  = '0;
      hold  = '0;
      addr  = '0;
      wdata = '0;
      repeat (3) tick();
      #2 rst_n = 1'b1;
      repeat (2) tick();

      // Single write from core 2 (rr_ptr 0 -> 3).
      c = cyc;
      drive(2, 1'b1, 16'h0010, 16'h00AB);
      exp_grant(2, 1'b1, 16'h0010, 16'h00AB, c + 1);
      drain();

      // Single read from core 1 (rr_ptr -> 2), then core 3 reads the write back (rr_ptr -> 0).
      c = cyc;
      drive(1, 1'b0, 16'h0020, 16'h0000);
      exp_grant(1, 1'b0, 16'h0020, 16'h0000, c + 1);
      exp_read(1, 16'h1234);
      drain();
      c = cyc;
      drive(3, 1'b0, 16'h0010, 16'h0000);
      exp_grant(3, 1'b0, 16'h0010, 16'h0000, c + 1);
      exp_read(3, 16'h00AB);
      drain();

      // All four cores read together: one grant every 3 cycles in order 0..3.
      c = cyc;
      for (int i = 0; i < N; i++) begin
         drive(i, 1'b0, 16'h0040 + 16'(i), 16'h0000);
         exp_grant(i, 1'b0, 16'h0040 + 16'(i), 16'h0000, c + 1 + 3 * i);
         exp_read(i, 16'hA000 + 16'(i));
      end
      drain();

      // Cores 0 and 3 again: pointer wrapped to 0, so core 0 first.
      c = cyc;
      drive(0, 1'b0, 16'h0040, 16'h0000);
      drive(3, 1'b0, 16'h0043, 16'h0000);
      exp_grant(0, 1'b0, 16'h0040, 16'h0000, c + 1);
      exp_read(0, 16'hA000);
      exp_grant(3, 1'b0, 16'h0043, 16'h0000, c + 4);
      exp_read(3, 16'hA003);
      drain();

      // Fairness: core 0 holds req, core 2 asks once; expected order 0, 2, 0.
      c = cyc;
      hold[0] = 1'b1;
      drive(0, 1'b1, 16'h0050, 16'h0001);
      drive(2, 1'b1, 16'h0052, 16'h0002);
      exp_grant(0, 1'b1, 16'h0050, 16'h0001, c + 1);
      exp_grant(2, 1'b1, 16'h0052, 16'h0002, c + 3);
      exp_grant(0, 1'b1, 16'h0050, 16'h0001, c + 5);
      wait_until(c + 5);
      req[0]  = 1'b0;
      hold[0] = 1'b0;
      drain();
      c = cyc;
      drive(1, 1'b0, 16'h0052, 16'h0000);
      exp_grant(1, 1'b0, 16'h0052, 16'h0000, c + 1);
      exp_read(1, 16'h0002);
      drain();

      // Reset during READ_WAIT: outputs clear at once, the read is dropped, pointer restarts at 0.
      c = cyc;
      drive(1, 1'b0, 16'h0020, 16'h0000);
      exp_grant(1, 1'b0, 16'h0020, 16'h0000, c + 1);
      wait_until(c + 2);
      #2 rst_n = 1'b0;
      #1 check("reset_async_mem_addr", mem_addr, 0);
      tick();
      req  = '0;
      hold = '0;
      #2 rst_n = 1'b1;
      repeat (4) tick();
      c = cyc;
      drive(0, 1'b1, 16'h0060, 16'h0060);
      drive(3, 1'b1, 16'h0063, 16'h0063);
      exp_grant(0, 1'b1, 16'h0060, 16'h0060, c + 1);
      exp_grant(3, 1'b1, 16'h0063, 16'h0063, c + 3);
      drain();

`ifdef ARB_LOCK_EN
      // Locked read-modify-write by core 1 while core 3 waits.
      c = cyc;
      hold[1] = 1'b1;
      lock[1] = 1'b1;
      drive(1, 1'b0, 16'h0030, 16'h0000);
      drive(3, 1'b0, 16'h0030, 16'h0000);
      exp_grant(1, 1'b0, 16'h0030, 16'h0000, c + 1);
      exp_read(1, 16'h0777);
      exp_grant(1, 1'b1, 16'h0030, 16'h5555, c + 4);
      exp_grant(3, 1'b0, 16'h0030, 16'h0000, c + 6);
      exp_read(3, 16'h5555);
      wait_until(c + 1);
      wr[1]             = 1'b1;
      wdata[1*DW +: DW] = 16'h5555;
      wait_until(c + 4);
      req[1]  = 1'b0;
      lock[1] = 1'b0;
      hold[1] = 1'b0;
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
